id_stage_pipe: RTL and testbench

//  Registered RV32I decode stage between IF and EX; successor to the combinational decoder.

---
 rtl/id_stage_pipe.sv | 266 ++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with operand forwarding, load-use hazard detection and branch
// resolution in ID. Results are held in an ID/EX register under a valid/ready handshake.
module id_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_inst,
  output logic [REG_AW-1:0]         rf_raddr1,
  output logic [REG_AW-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_aluop,
  output logic [2:0]                out_alusel,
  output logic [XLEN-1:0]           out_reg1,
  output logic [XLEN-1:0]           out_reg2,
  output logic [XLEN-1:0]           out_imm,
  output logic [REG_AW-1:0]         out_wd,
  output logic                      out_wreg,
  output logic                      out_is_load,
  output logic                      out_illegal,
  output logic                      redirect_valid,
  output logic [XLEN-1:0]           redirect_target
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [7:0] EXE_NOP_OP  = 8'h00;
  localparam logic [7:0] EXE_ADD_OP  = 8'h01;
  localparam logic [7:0] EXE_SUB_OP  = 8'h02;
  localparam logic [7:0] EXE_SLL_OP  = 8'h03;
  localparam logic [7:0] EXE_SLT_OP  = 8'h04;
  localparam logic [7:0] EXE_SLTU_OP = 8'h05;
  localparam logic [7:0] EXE_XOR_OP  = 8'h06;
  localparam logic [7:0] EXE_SRL_OP  = 8'h07;
  localparam logic [7:0] EXE_SRA_OP  = 8'h08;
  localparam logic [7:0] EXE_OR_OP   = 8'h09;
  localparam logic [7:0] EXE_AND_OP  = 8'h0a;

  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_ARITH = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd3;
  localparam logic [2:0] EXE_RES_JUMP  = 3'd4;
  localparam logic [2:0] EXE_RES_LOAD  = 3'd5;
  localparam logic [2:0] EXE_RES_STORE = 3'd6;

  logic [6:0]        opcode, f7;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, pc_link;

  assign opcode    = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign f7        = in_inst[31:25];
  assign rd        = REG_AW'(in_inst[11:7]);
  assign rs1       = REG_AW'(in_inst[19:15]);
  assign rs2       = REG_AW'(in_inst[24:20]);
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u32 = {in_inst[31:12], 12'b0};
  assign imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i32);
  assign imm_s   = XLEN'(imm_s32);
  assign imm_b   = XLEN'(imm_b32);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_j   = XLEN'(imm_j32);
  assign pc_link = in_pc + XLEN'(4);

  // Lowest-index (youngest) matching source wins; x0 is never forwarded.
  logic [XLEN-1:0] op1, op2;
  logic            hit1, hit2, pend1, pend2;

  always_comb begin
    op1 = rf_rdata1; hit1 = 1'b0; pend1 = 1'b0;
    op2 = rf_rdata2; hit2 = 1'b0; pend2 = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit1 && fwd_wreg[i] && (fwd_wd[i*REG_AW +: REG_AW] == rs1)) begin
        hit1  = 1'b1;
        op1   = fwd_wdata[i*XLEN +: XLEN];
        pend1 = fwd_pending[i];
      end
      if (!hit2 && fwd_wreg[i] && (fwd_wd[i*REG_AW +: REG_AW] == rs2)) begin
        hit2  = 1'b1;
        op2   = fwd_wdata[i*XLEN +: XLEN];
        pend2 = fwd_pending[i];
      end
    end
    if (rs1 == '0) begin op1 = '0; pend1 = 1'b0; end
    if (rs2 == '0) begin op2 = '0; pend2 = 1'b0; end
  end

  // funct7 bit 30 selects SUB/SRA; for OP-IMM it only matters on the shift-right slot.
  logic       alt;
  logic [7:0] f3_op;
  logic [2:0] f3_sel;

  assign alt = ((opcode == OPC_OP) || (f3 == 3'd5)) && in_inst[30];

  always_comb begin
    f3_op  = EXE_NOP_OP;
    f3_sel = EXE_RES_NOP;
    case (f3)
      3'd0: begin f3_op = alt ? EXE_SUB_OP : EXE_ADD_OP; f3_sel = EXE_RES_ARITH; end
      3'd1: begin f3_op = EXE_SLL_OP;  f3_sel = EXE_RES_SHIFT; end
      3'd2: begin f3_op = EXE_SLT_OP;  f3_sel = EXE_RES_ARITH; end
      3'd3: begin f3_op = EXE_SLTU_OP; f3_sel = EXE_RES_ARITH; end
      3'd4: begin f3_op = EXE_XOR_OP;  f3_sel = EXE_RES_LOGIC; end
      3'd5: begin f3_op = alt ? EXE_SRA_OP : EXE_SRL_OP; f3_sel = EXE_RES_SHIFT; end
      3'd6: begin f3_op = EXE_OR_OP;   f3_sel = EXE_RES_LOGIC; end
      default: begin f3_op = EXE_AND_OP; f3_sel = EXE_RES_LOGIC; end
    endcase
  end

  logic            br_cond;
  always_comb begin
    case (f3)
      3'd0:    br_cond = (op1 == op2);
      3'd1:    br_cond = (op1 != op2);
      3'd4:    br_cond = ($signed(op1) <  $signed(op2));
      3'd5:    br_cond = ($signed(op1) >= $signed(op2));
      3'd6:    br_cond = (op1 <  op2);
      default: br_cond = (op1 >= op2);
    endcase
  end

  logic [7:0]      d_aluop;
  logic [2:0]      d_alusel;
  logic [XLEN-1:0] d_reg1, d_reg2, d_imm, d_target;
  logic            d_wreg, d_is_load, d_illegal, d_redir, use1, use2;

  always_comb begin
    d_aluop   = EXE_NOP_OP;
    d_alusel  = EXE_RES_NOP;
    d_reg1    = '0;
    d_reg2    = '0;
    d_imm     = '0;
    d_target  = '0;
    d_wreg    = 1'b0;
    d_is_load = 1'b0;
    d_illegal = 1'b0;
    d_redir   = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    case (opcode)
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1;
        d_reg1 = op1; d_reg2 = op2;
        d_aluop = f3_op; d_alusel = f3_sel; d_wreg = 1'b1;
        d_illegal = !((f7 == 7'b0) || ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_OPIMM: begin
        use1 = 1'b1;
        d_reg1 = op1; d_reg2 = imm_i; d_imm = imm_i;
        d_aluop = f3_op; d_alusel = f3_sel; d_wreg = 1'b1;
        if (f3 == 3'd1)      d_illegal = (f7 != 7'b0);
        else if (f3 == 3'd5) d_illegal = !((f7 == 7'b0) || (f7 == 7'b0100000));
      end
      OPC_LUI: begin
        d_reg1 = imm_u; d_imm = imm_u;
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_ARITH; d_wreg = 1'b1;
      end
      OPC_AUIPC: begin
        d_reg1 = imm_u; d_reg2 = in_pc; d_imm = imm_u;
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_ARITH; d_wreg = 1'b1;
      end
      OPC_JAL: begin
        d_reg1 = pc_link; d_imm = imm_j;
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_JUMP; d_wreg = 1'b1;
        d_target = in_pc + imm_j; d_redir = 1'b1;
      end
      OPC_JALR: begin
        use1 = 1'b1;
        d_reg1 = pc_link; d_imm = imm_i;
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_JUMP; d_wreg = 1'b1;
        d_target = (op1 + imm_i) & ~XLEN'(1); d_redir = 1'b1;
        d_illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1;
        d_reg1 = op1; d_reg2 = op2; d_imm = imm_b;
        d_target = in_pc + imm_b; d_redir = br_cond;
        d_illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        use1 = 1'b1;
        d_reg1 = op1; d_reg2 = imm_i; d_imm = imm_i;
        d_aluop = {5'b00010, f3}; d_alusel = EXE_RES_LOAD; d_wreg = 1'b1; d_is_load = 1'b1;
        d_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1;
        d_reg1 = op1; d_reg2 = op2; d_imm = imm_s;
        d_aluop = {5'b00011, f3}; d_alusel = EXE_RES_STORE;
        d_illegal = (f3 > 3'd2);
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_aluop = EXE_NOP_OP; d_alusel = EXE_RES_NOP;
      d_wreg = 1'b0; d_is_load = 1'b0; d_redir = 1'b0;
    end
    if (rd == '0) d_wreg = 1'b0;
  end

  logic hazard, accept;

  assign hazard          = in_valid && ((use1 && pend1) || (use2 && pend2));
  assign in_ready        = !hazard && (!out_valid || out_ready);
  assign accept          = in_valid && in_ready && !flush_i;
  assign redirect_valid  = accept && d_redir;
  assign redirect_target = d_target;

  // A drained or bubbled slot returns to the same idle values as reset.
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!accept && (!out_valid || out_ready))) begin
      out_valid   <= 1'b0;
      out_aluop   <= EXE_NOP_OP;
      out_alusel  <= EXE_RES_NOP;
      out_reg1    <= '0;
      out_reg2    <= '0;
      out_imm     <= '0;
      out_wd      <= '0;
      out_wreg    <= 1'b0;
      out_is_load <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_aluop   <= d_aluop;
      out_alusel  <= d_alusel;
      out_reg1    <= d_reg1;
      out_reg2    <= d_reg2;
      out_imm     <= d_imm;
      out_wd      <= rd;
      out_wreg    <= d_wreg;
      out_is_load <= d_is_load;
      out_illegal <= d_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: forwarding priority, load-use bubble, branch/jump
// redirects, stall hold, flush and reset behaviour with hand-computed expectations.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid, in_ready, out_ready;
  logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [1:0]  fwd_wreg, fwd_pending;
  logic [9:0]  fwd_wd;
  logic [63:0] fwd_wdata;
  logic        out_valid, out_wreg, out_is_load, out_illegal, redirect_valid;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [31:0] out_reg1, out_reg2, out_imm, redirect_target;
  logic [4:0]  out_wd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm), .out_wd(out_wd),
    .out_wreg(out_wreg), .out_is_load(out_is_load), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 32'h0; in_inst = 32'h0; rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hDEAD;
    fwd_wreg = 2'b00; fwd_wd = '0; fwd_wdata = '0; fwd_pending = 2'b00;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_aluop", 32'(out_aluop), 32'd0);
    chk("rst_alusel", 32'(out_alusel), 32'd0);
    chk("rst_wreg", 32'(out_wreg), 32'd0);
    chk("rst_reg1", out_reg1, 32'd0);
    chk("rst_redir", 32'(redirect_valid), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    in_valid = 1'b1; in_inst = 32'h00500093; #1;
    chk("t1_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_reg1", out_reg1, 32'd0);
    chk("t1_reg2", out_reg2, 32'd5);
    chk("t1_wd", 32'(out_wd), 32'd1);
    chk("t1_aluop", 32'(out_aluop), 32'h01);
    chk("t1_alusel", 32'(out_alusel), 32'd1);

    // add x2,x1,x1 with x1 forwarded from EX
    in_inst = 32'h00108133; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_wdata = {32'h0, 32'd5};
    tick();
    chk("t1_add_reg1", out_reg1, 32'd5);
    chk("t1_add_reg2", out_reg2, 32'd5);
    chk("t1_add_wd", 32'(out_wd), 32'd2);
    chk("t1_add_wreg", 32'(out_wreg), 32'd1);

    // addi x6,x3,1 : EX beats MEM, then MEM alone, then regfile
    in_inst = 32'h00118313; fwd_wreg = 2'b11; fwd_wd = {5'd3, 5'd3}; fwd_wdata = {32'd9, 32'd7};
    tick();
    chk("t2_prio", out_reg1, 32'd7);
    chk("t2_imm", out_reg2, 32'd1);
    fwd_wreg = 2'b10;
    tick();
    chk("t2_older", out_reg1, 32'd9);
    fwd_wreg = 2'b00;
    tick();
    chk("t2_rf", out_reg1, 32'hDEAD);
    // addi x6,x0,1 with a source claiming x0
    in_inst = 32'h00100313; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'h55};
    tick();
    chk("t2_x0", out_reg1, 32'd0);

    // add x5,x4,x4 with lw x4 in EX
    in_inst = 32'h004202B3; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd4};
    fwd_wdata = {32'h0, 32'h44}; fwd_pending = 2'b01; #1;
    chk("t3_stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t3_bubble", 32'(out_valid), 32'd0);
    chk("t3_bubble_wreg", 32'(out_wreg), 32'd0);
    fwd_pending = 2'b00; #1;
    chk("t3_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_reg1", out_reg1, 32'h44);
    chk("t3_reg2", out_reg2, 32'h44);
    chk("t3_wd", 32'(out_wd), 32'd5);
    // only the first match decides the hazard
    fwd_wreg = 2'b11; fwd_wd = {5'd4, 5'd4}; fwd_wdata = {32'h99, 32'h11}; fwd_pending = 2'b10; #1;
    chk("t3_first_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3_first_reg1", out_reg1, 32'h11);
    fwd_wreg = 2'b00; fwd_pending = 2'b00;

    // lw x4,0(x1)
    in_inst = 32'h0000A203; rf_rdata1 = 32'h1000;
    tick();
    chk("ld_is_load", 32'(out_is_load), 32'd1);
    chk("ld_aluop", 32'(out_aluop), 32'h12);
    chk("ld_alusel", 32'(out_alusel), 32'd5);
    chk("ld_reg1", out_reg1, 32'h1000);
    chk("ld_wd", 32'(out_wd), 32'd4);

    // beq x1,x1,+16 at 0x100
    rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hDEAD;
    in_pc = 32'h100; in_inst = 32'h00108863; #1;
    chk("t4_redir", 32'(redirect_valid), 32'd1);
    chk("t4_target", redirect_target, 32'h110);
    tick();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_wreg", 32'(out_wreg), 32'd0);
    chk("t4_imm", out_imm, 32'd16);
    in_valid = 1'b0; #1;
    chk("t4_pulse_end", 32'(redirect_valid), 32'd0);
    tick();
    chk("t4_drain", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_inst = 32'h00109863; #1;
    chk("t4_bne", 32'(redirect_valid), 32'd0);
    tick();
    // beq during a hazard must not redirect
    in_inst = 32'h00108863; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_pending = 2'b01; #1;
    chk("t4_hz_redir", 32'(redirect_valid), 32'd0);
    chk("t4_hz_ready", 32'(in_ready), 32'd0);
    fwd_wreg = 2'b00; fwd_pending = 2'b00;
    tick();

    // jalr x1,8(x2) at 0x300, x2=0x203
    in_pc = 32'h300; in_inst = 32'h008100E7; rf_rdata1 = 32'h203; #1;
    chk("t5_redir", 32'(redirect_valid), 32'd1);
    chk("t5_target", redirect_target, 32'h20A);
    tick();
    chk("t5_link", out_reg1, 32'h304);
    chk("t5_wreg", 32'(out_wreg), 32'd1);
    chk("t5_wd", 32'(out_wd), 32'd1);
    chk("t5_alusel", 32'(out_alusel), 32'd4);
    // jal x0,-4 at 0 wraps
    in_pc = 32'h0; in_inst = 32'hFFDFF06F; #1;
    chk("jal_target", redirect_target, 32'hFFFFFFFC);
    tick();
    chk("jal_wreg", 32'(out_wreg), 32'd0);

    // lui x7,0x12345
    in_inst = 32'h123453B7;
    tick();
    chk("lui_reg1", out_reg1, 32'h12345000);
    chk("lui_reg2", out_reg2, 32'd0);
    // sw x2,-4(x1)
    in_inst = 32'hFE20AE23; rf_rdata1 = 32'h1000; rf_rdata2 = 32'hBEEF;
    tick();
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_reg2", out_reg2, 32'hBEEF);
    chk("sw_wreg", 32'(out_wreg), 32'd0);
    chk("sw_alusel", 32'(out_alusel), 32'd6);
    // unknown opcode, rd=3
    in_inst = 32'h000001FF; #1;
    chk("ill_redir", 32'(redirect_valid), 32'd0);
    tick();
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_wreg", 32'(out_wreg), 32'd0);
    chk("ill_aluop", 32'(out_aluop), 32'd0);

    // stall: hold for 3 cycles, then flush
    in_inst = 32'h00500093;
    tick();
    out_ready = 1'b0; in_pc = 32'h100; in_inst = 32'h00108863; #1;
    chk("t6_ready", 32'(in_ready), 32'd0);
    chk("t6_redir", 32'(redirect_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_valid", 32'(out_valid), 32'd1);
      chk("t6_hold_reg2", out_reg2, 32'd5);
      chk("t6_hold_wd", 32'(out_wd), 32'd1);
    end
    flush_i = 1'b1; #1;
    chk("t6_flush_redir", 32'(redirect_valid), 32'd0);
    tick();
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    chk("t6_flush_wreg", 32'(out_wreg), 32'd0);
    // flush beats an accept
    out_ready = 1'b1; in_inst = 32'h00500093;
    tick();
    chk("flush_wins", 32'(out_valid), 32'd0);
    flush_i = 1'b0;
    tick();
    chk("post_flush_valid", 32'(out_valid), 32'd1);

    // reset while stalled discards the held instruction
    out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_reg2", out_reg2, 32'd0);
    rst = 1'b0; #1;
    chk("rst_after_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rst_after_valid", 32'(out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
